spi_slave: RTL and testbench

//  SPI target (slave) end of the spi_master link: receives MOSI bytes and returns MISO bytes
//  on master-driven sck/ssn. Oversamples sck in the clk domain; sck must be <= clk/4
//  (spibr >= 1). Sits beside spi_master in the SoC to build loopback/peer systems.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_sync.sv | 62 ++++++
 rtl/spi_slave.sv | 157 +++++++++++++++
 tb/tb_spi_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared control-register bit positions and FSM state encoding for the SPI target.
package spi_pkg;

    localparam int unsigned SPCON_SPE   = 6;
    localparam int unsigned SPCON_LSBFE = 5;
    localparam int unsigned SPCON_CPOL  = 3;
    localparam int unsigned SPCON_CPHA  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER
    } spi_s_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Input conditioning for the SPI target: optional 2-flop synchronisers (SPI_SLAVE_SYNC_EN)
// followed by sck leading/trailing edge strobes and an ssn falling-edge strobe.
module spi_slave_sync (
    input  logic clk,
    input  logic rst,
    input  logic cpol,
    input  logic sck,
    input  logic ssn,
    input  logic mosi,
    output logic ssn_c,
    output logic mosi_c,
    output logic lead_c,
    output logic trail_c,
    output logic ssn_fall_c
);

    logic sck_c;
    logic sck_q;
    logic ssn_q;

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] sck_ff;
    logic [1:0] ssn_ff;
    logic [1:0] mosi_ff;

    // Idle-level reset values so release from reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_ff  <= {2{cpol}};
            ssn_ff  <= 2'b11;
            mosi_ff <= 2'b00;
        end else begin
            sck_ff  <= {sck_ff[0], sck};
            ssn_ff  <= {ssn_ff[0], ssn};
            mosi_ff <= {mosi_ff[0], mosi};
        end
    end

    assign sck_c  = sck_ff[1];
    assign ssn_c  = ssn_ff[1];
    assign mosi_c = mosi_ff[1];
`else
    assign sck_c  = sck;
    assign ssn_c  = ssn;
    assign mosi_c = mosi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= cpol;
            ssn_q <= 1'b1;
        end else begin
            sck_q <= sck_c;
            ssn_q <= ssn_c;
        end
    end

    assign lead_c     = (sck_c != sck_q) && (sck_c != cpol);
    assign trail_c    = (sck_c != sck_q) && (sck_c == cpol);
    assign ssn_fall_c = ssn_q && !ssn_c;

endmodule

// File: rtl/spi_slave.sv
// SPI target end of the spi_master link: oversampled sck/ssn, all four CPOL/CPHA modes,
// MSB/LSB first, back-to-back frames. Define SPI_SLAVE_SYNC_EN to synchronise sck/ssn/mosi.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        spcon,
    input  logic [DATA_W-1:0] data_s,
    output logic [DATA_W-1:0] data_r_s,
    output logic              data_finish_s,
    input  logic              sck,
    input  logic              ssn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_s_state_e state, state_next;

    logic              spe, lsbfe, cpol, cpha;
    logic              ssn_c, mosi_c, lead_c, trail_c, ssn_fall_c;
    logic              load_c, abort_c, sample_c, shift_c, last_c;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_next_c;
    logic              unused_spcon;

    assign spe   = spcon[SPCON_SPE];
    assign lsbfe = spcon[SPCON_LSBFE];
    assign cpol  = spcon[SPCON_CPOL];
    assign cpha  = spcon[SPCON_CPHA];
    assign unused_spcon = ^{spcon[7], spcon[4], spcon[1:0]};

    function automatic logic first_bit(input logic [DATA_W-1:0] x, input logic lsb);
        return lsb ? x[0] : x[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] x, input logic lsb);
        return lsb ? (x >> 1) : (x << 1);
    endfunction

    spi_slave_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .cpol       (cpol),
        .sck        (sck),
        .ssn        (ssn),
        .mosi       (mosi),
        .ssn_c      (ssn_c),
        .mosi_c     (mosi_c),
        .lead_c     (lead_c),
        .trail_c    (trail_c),
        .ssn_fall_c (ssn_fall_c)
    );

    assign rx_next_c = lsbfe ? {mosi_c, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_c};
    assign last_c    = (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus per-cycle strobes; bit_cnt==0 in XFER with CPHA=0 marks the trailing
    // edge right after a frame wrap, whose shift would discard the freshly loaded bit0.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        abort_c    = 1'b0;
        sample_c   = 1'b0;
        shift_c    = 1'b0;
        case (state)
            IDLE: begin
                if (spe && ssn_fall_c) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (!spe || ssn_c) begin
                    abort_c    = 1'b1;
                    state_next = IDLE;
                end else begin
                    load_c     = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (!spe || ssn_c) begin
                    abort_c    = 1'b1;
                    state_next = IDLE;
                end else begin
                    sample_c = cpha ? trail_c : lead_c;
                    shift_c  = cpha ? lead_c : (trail_c && (bit_cnt != '0));
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_sr holds the bits not yet driven onto miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r_s      <= '0;
            data_finish_s <= 1'b0;
            miso          <= 1'b0;
            miso_oe       <= 1'b0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
        end else begin
            data_finish_s <= 1'b0;
            if (abort_c) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (load_c) begin
                miso_oe <= 1'b1;
                bit_cnt <= '0;
                rx_sr   <= '0;
                tx_sr   <= cpha ? data_s : drop_bit(data_s, lsbfe);
                miso    <= cpha ? 1'b0 : first_bit(data_s, lsbfe);
            end else begin
                if (sample_c) begin
                    rx_sr <= rx_next_c;
                    if (last_c) begin
                        data_r_s      <= rx_next_c;
                        data_finish_s <= 1'b1;
                        bit_cnt       <= '0;
                        if (cpha) begin
                            tx_sr <= data_s;
                        end else begin
                            tx_sr <= drop_bit(data_s, lsbfe);
                            miso  <= first_bit(data_s, lsbfe);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (shift_c) begin
                    miso  <= first_bit(tx_sr, lsbfe);
                    tx_sr <= drop_bit(tx_sr, lsbfe);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave with a behavioural spi_master peer (4 clk per sck half).
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spcon;
    logic [7:0] data_s;
    logic [7:0] data_r_s;
    logic       data_finish_s;
    logic       sck;
    logic       ssn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int oe_cnt    = 0;
    logic [7:0] pulse_log [4];

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .spcon         (spcon),
        .data_s        (data_s),
        .data_r_s      (data_r_s),
        .data_finish_s (data_finish_s),
        .sck           (sck),
        .ssn           (ssn),
        .mosi          (mosi),
        .miso          (miso),
        .miso_oe       (miso_oe)
    );

    always @(negedge clk) begin
        if (data_finish_s) begin
            pulse_log[2'(pulse_cnt)] = data_r_s;
            pulse_cnt++;
        end
        if (miso_oe) oe_cnt++;
    end

    typedef struct {
        logic [7:0] spcon;
        logic [7:0] m_tx;
        logic [7:0] s_tx;
        logic [7:0] exp_r_s;
        logic [7:0] exp_r_m;
        logic       m_lsbfe;
    } vec_t;

    vec_t vecs [7];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural master: drives on negedge, samples miso just before moving sck.
    task automatic master_xfer(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                               input int abort_at, input logic m_lsbfe,
                               output logic [7:0] r0, output logic [7:0] r1);
        logic       cpol, cpha, mbit;
        logic [7:0] tx, rx;
        logic [2:0] idx;
        bit         aborted;
        cpol = spcon[3];
        cpha = spcon[2];
        r0 = 8'h00;
        r1 = 8'h00;
        mbit = 1'b0;
        aborted = 0;
        sck = cpol;
        tick(2);
        ssn = 1'b0;
        for (int b = 0; b < nbytes && !aborted; b++) begin
            tx = (b == 0) ? b0 : b1;
            rx = 8'h00;
            if (!cpha) mosi = m_lsbfe ? tx[0] : tx[7];
            if (b == 0) tick(4);
            for (int i = 0; i < 8; i++) begin
                if (i == abort_at) begin
                    aborted = 1;
                    break;
                end
                if (!cpha) mbit = miso;
                sck = ~cpol;
                if (cpha) begin
                    idx = m_lsbfe ? 3'(i) : 3'(7 - i);
                    mosi = tx[idx];
                end
                tick(4);
                if (cpha) mbit = miso;
                sck = cpol;
                if (!cpha && i < 7) begin
                    idx = m_lsbfe ? 3'(i + 1) : 3'(6 - i);
                    mosi = tx[idx];
                end
                tick(4);
                rx = m_lsbfe ? {mbit, rx[7:1]} : {rx[6:0], mbit};
            end
            if (b == 0) r0 = rx; else r1 = rx;
        end
        ssn = 1'b1;
        tick(4);
    endtask

    initial begin
        logic [7:0] r0, r1;
        int p0, o0;

        vecs[0] = '{8'h40, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0};
        vecs[1] = '{8'h4C, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 1'b0};
        vecs[2] = '{8'h60, 8'h01, 8'h96, 8'h01, 8'h96, 1'b1};
        vecs[3] = '{8'h60, 8'h01, 8'h0F, 8'h80, 8'hF0, 1'b0};
        vecs[4] = '{8'h44, 8'hC6, 8'h81, 8'hC6, 8'h81, 1'b0};
        vecs[5] = '{8'h48, 8'h3E, 8'hE7, 8'h3E, 8'hE7, 1'b0};
        vecs[6] = '{8'h6C, 8'h2D, 8'hB4, 8'h2D, 8'hB4, 1'b1};

        rst = 1'b1; sck = 1'b0; ssn = 1'b1; mosi = 1'b0; spcon = 8'h00; data_s = 8'h00;
        tick(3);
        check("reset data_r_s", int'(data_r_s), 0);
        check("reset data_finish_s", int'(data_finish_s), 0);
        check("reset miso", int'(miso), 0);
        check("reset miso_oe", int'(miso_oe), 0);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            spcon  = vecs[v].spcon;
            data_s = vecs[v].s_tx;
            p0 = pulse_cnt;
            master_xfer(vecs[v].m_tx, 8'h00, 1, 8, vecs[v].m_lsbfe, r0, r1);
            check($sformatf("vec%0d data_r_s", v), int'(data_r_s), int'(vecs[v].exp_r_s));
            check($sformatf("vec%0d master rx", v), int'(r0), int'(vecs[v].exp_r_m));
            check($sformatf("vec%0d pulses", v), pulse_cnt - p0, 1);
            check($sformatf("vec%0d miso_oe idle", v), int'(miso_oe), 0);
            check($sformatf("vec%0d miso idle", v), int'(miso), 0);
        end

        // Abort after 4 sck cycles keeps the previous byte.
        spcon = 8'h40; data_s = 8'h3C;
        master_xfer(8'hA5, 8'h00, 1, 8, 1'b0, r0, r1);
        check("abort prior byte", int'(data_r_s), 'hA5);
        p0 = pulse_cnt;
        master_xfer(8'hFF, 8'h00, 1, 4, 1'b0, r0, r1);
        check("abort pulses", pulse_cnt - p0, 0);
        check("abort data_r_s", int'(data_r_s), 'hA5);
        check("abort miso_oe", int'(miso_oe), 0);

        // Two bytes under one ssn low.
        data_s = 8'h77;
        p0 = pulse_cnt;
        master_xfer(8'h11, 8'h22, 2, 8, 1'b0, r0, r1);
        check("b2b pulses", pulse_cnt - p0, 2);
        check("b2b first byte", int'(pulse_log[2'(p0)]), 'h11);
        check("b2b second byte", int'(pulse_log[2'(p0 + 1)]), 'h22);
        check("b2b master rx0", int'(r0), 'h77);
        check("b2b master rx1", int'(r1), 'h77);

        // Reset in the middle of a frame.
        spcon = 8'h40; data_s = 8'h3C; sck = 1'b0;
        tick(2);
        ssn = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(2);
        check("midframe miso_oe", int'(miso_oe), 1);
        rst = 1'b1;
        tick(1);
        check("midrst data_r_s", int'(data_r_s), 0);
        check("midrst data_finish_s", int'(data_finish_s), 0);
        check("midrst miso", int'(miso), 0);
        check("midrst miso_oe", int'(miso_oe), 0);
        rst = 1'b0; sck = 1'b0; ssn = 1'b1;
        tick(4);

        // SPE cleared: the slave must stay silent.
        spcon = 8'h00; data_s = 8'h3C;
        p0 = pulse_cnt;
        o0 = oe_cnt;
        master_xfer(8'hA5, 8'h00, 1, 8, 1'b0, r0, r1);
        check("spe0 pulses", pulse_cnt - p0, 0);
        check("spe0 miso_oe cycles", oe_cnt - o0, 0);
        check("spe0 data_r_s", int'(data_r_s), 0);
        check("spe0 master rx", int'(r0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
